// File: rtl/pong_anim_graph.sv
// rtl/pong_anim_graph.sv - animated Pong wall/paddle/ball renderer with serve/play FSM
//
// Purpose: owns the wall, a button-driven paddle and a bouncing square ball.
// All positions advance once per video frame (one-clk tick derived from the
// pixel counters). Detects wall/top/bottom bounces, paddle returns and misses,
// and produces the registered 12-bit pixel colour.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous, active-low reset
//   vid_on   - active-video flag from the sync block
//   pixl_x   - current pixel column (10 bits)
//   pixl_y   - current pixel row (10 bits)
//   btn_up   - paddle up (debounced, synchronised)
//   btn_dn   - paddle down (debounced, synchronised)
//   rgb      - registered pixel colour (12 bits, 1 clk latency)
//   hit      - one-clk pulse on a paddle return
//   miss     - one-clk pulse when the ball is lost
module pong_anim_graph #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int REFR_Y       = 481,
  parameter int WALL_L       = 32,
  parameter int WALL_R       = 35,
  parameter int PAD_L        = 600,
  parameter int PAD_R        = 603,
  parameter int PAD_H        = 72,
  parameter int PAD_V        = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V       = 2,
  parameter int SERVE_X      = 320,
  parameter int SERVE_Y      = 236,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_on,
  input  logic [9:0]  pixl_x,
  input  logic [9:0]  pixl_y,
  input  logic        btn_up,
  input  logic        btn_dn,
  output logic [11:0] rgb,
  output logic        hit,
  output logic        miss
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  // 11-bit copies of the geometry so every compare has headroom and cannot wrap
  localparam logic [10:0] W_H_MAX   = 11'(H_MAX);
  localparam logic [10:0] W_V_MAX   = 11'(V_MAX);
  localparam logic [10:0] W_WALL_L  = 11'(WALL_L);
  localparam logic [10:0] W_WALL_R  = 11'(WALL_R);
  localparam logic [10:0] W_PAD_L   = 11'(PAD_L);
  localparam logic [10:0] W_PAD_R   = 11'(PAD_R);
  localparam logic [10:0] W_PAD_H   = 11'(PAD_H);
  localparam logic [10:0] W_PAD_V   = 11'(PAD_V);
  localparam logic [10:0] W_SIZE    = 11'(BALL_SIZE);
  localparam logic [10:0] W_BALL_V  = 11'(BALL_V);
  localparam logic [10:0] W_PAD_MAX = 11'(V_MAX - PAD_H);

  localparam logic [9:0]  REFR_Y_P  = 10'(REFR_Y);
  localparam logic [9:0]  PAD_INIT  = 10'((V_MAX - PAD_H) / 2);
  localparam logic [9:0]  SRV_X     = 10'(SERVE_X);
  localparam logic [9:0]  SRV_Y     = 10'(SERVE_Y);
  localparam logic [9:0]  STEP_B    = 10'(BALL_V);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  // dx: 1 = right, 0 = left. dy: 1 = down, 0 = up.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [9:0]       pad_top, pad_next;
  logic [9:0]       ball_x, ball_y, ball_x_next, ball_y_next;
  logic             dx, dy, dx_next, dy_next;
  logic             hit_c, miss_c;

  // ---------------------------------------------------------------------------
  // Frame tick: rising edge of the registered (0, REFR_Y) match, so exactly one
  // clk per frame no matter how many clks each pixel lasts.
  // ---------------------------------------------------------------------------
  logic fr_cond, fr_cond_reg, fr_d, tick;

  assign fr_cond = (pixl_y == REFR_Y_P) && (pixl_x == 10'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fr_cond_reg <= 1'b0;
      fr_d        <= 1'b0;
    end else begin
      fr_cond_reg <= fr_cond;
      fr_d        <= fr_cond_reg;
    end
  end

  assign tick = fr_cond_reg & ~fr_d;

  // ---------------------------------------------------------------------------
  // Zero-extended positions and object extents
  // ---------------------------------------------------------------------------
  logic [10:0] pad_w, bx_w, by_w, px_w, py_w;
  logic [10:0] pad_bot, ball_rgt, ball_bot;
  logic [10:0] pad_dn_sum, pad_up_dif;

  assign pad_w    = {1'b0, pad_top};
  assign bx_w     = {1'b0, ball_x};
  assign by_w     = {1'b0, ball_y};
  assign px_w     = {1'b0, pixl_x};
  assign py_w     = {1'b0, pixl_y};
  assign pad_bot  = pad_w + W_PAD_H - 11'd1;
  assign ball_rgt = bx_w + W_SIZE - 11'd1;
  assign ball_bot = by_w + W_SIZE - 11'd1;

  // ---------------------------------------------------------------------------
  // Paddle: clamped move, evaluated before the add/subtract can leave range
  // ---------------------------------------------------------------------------
  assign pad_dn_sum = pad_w + W_PAD_V;
  assign pad_up_dif = pad_w - W_PAD_V;

  always_comb begin
    pad_next = pad_top;
    if (btn_dn && !btn_up) begin
      if (pad_dn_sum > W_PAD_MAX) pad_next = W_PAD_MAX[9:0];
      else                        pad_next = pad_dn_sum[9:0];
    end else if (btn_up && !btn_dn) begin
      if (pad_w < W_PAD_V) pad_next = 10'd0;
      else                 pad_next = pad_up_dif[9:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SERVE;
    else if (tick) state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      SERVE:   if (count == SERVE_LAST) state_next = PLAY;
      PLAY:    if (miss_c) state_next = SERVE;
      default: state_next = SERVE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: per-state outputs (ball motion, serve count, collision flags).
  // Directions are resolved from pre-tick positions, then the ball steps along
  // the resolved directions. A miss suppresses the step and re-serves.
  // ---------------------------------------------------------------------------
  logic overlap;
  assign overlap = (by_w <= pad_bot) && (ball_bot >= pad_w);

  always_comb begin
    dx_next     = dx;
    dy_next     = dy;
    ball_x_next = ball_x;
    ball_y_next = ball_y;
    count_next  = count;
    hit_c       = 1'b0;
    miss_c      = 1'b0;
    case (state)
      SERVE: begin
        ball_x_next = SRV_X;
        ball_y_next = SRV_Y;
        if (count == SERVE_LAST) begin
          count_next = '0;
          dx_next    = DIR_RIGHT;
          dy_next    = DIR_DOWN;
        end else begin
          count_next = count + 1'b1;
        end
      end
      PLAY: begin
        if (dy == DIR_UP && by_w < W_BALL_V)
          dy_next = DIR_DOWN;
        if (dy == DIR_DOWN && (by_w + W_SIZE + W_BALL_V) > W_V_MAX)
          dy_next = DIR_UP;
        if (dx == DIR_LEFT && bx_w <= (W_WALL_R + W_BALL_V))
          dx_next = DIR_RIGHT;

        // paddle takes precedence over the miss line
        if (dx == DIR_RIGHT && (ball_rgt + W_BALL_V) >= W_PAD_L &&
            ball_rgt <= W_PAD_R && overlap) begin
          dx_next = DIR_LEFT;
          hit_c   = 1'b1;
        end else if (dx == DIR_RIGHT && (ball_rgt + W_BALL_V) >= (W_H_MAX - 11'd1)) begin
          miss_c  = 1'b1;
        end

        if (miss_c) begin
          ball_x_next = SRV_X;
          ball_y_next = SRV_Y;
          count_next  = '0;
        end else begin
          ball_x_next = (dx_next == DIR_RIGHT) ? ball_x + STEP_B : ball_x - STEP_B;
          ball_y_next = (dy_next == DIR_DOWN)  ? ball_y + STEP_B : ball_y - STEP_B;
        end
      end
      default: begin
        ball_x_next = SRV_X;
        ball_y_next = SRV_Y;
        count_next  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Object registers and event pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pad_top <= PAD_INIT;
      ball_x  <= SRV_X;
      ball_y  <= SRV_Y;
      dx      <= DIR_RIGHT;
      dy      <= DIR_DOWN;
      hit     <= 1'b0;
      miss    <= 1'b0;
    end else begin
      hit  <= tick & hit_c;
      miss <= tick & miss_c;
      if (tick) begin
        count   <= count_next;
        pad_top <= pad_next;
        ball_x  <= ball_x_next;
        ball_y  <= ball_y_next;
        dx      <= dx_next;
        dy      <= dy_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Render: wall over paddle over ball over background, one clk latency
  // ---------------------------------------------------------------------------
  logic        wall_on, pad_on, ball_on;
  logic [11:0] rgb_next;

  assign wall_on = (px_w >= W_WALL_L) && (px_w <= W_WALL_R);
  assign pad_on  = (px_w >= W_PAD_L) && (px_w <= W_PAD_R) &&
                   (py_w >= pad_w) && (py_w <= pad_bot);
  assign ball_on = (px_w >= bx_w) && (px_w <= ball_rgt) &&
                   (py_w >= by_w) && (py_w <= ball_bot);

  always_comb begin
    rgb_next = 12'h000;
    if (vid_on) begin
      if (wall_on)      rgb_next = 12'h00F;
      else if (pad_on)  rgb_next = 12'h0F0;
      else if (ball_on) rgb_next = 12'hF00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb <= 12'h000;
    else          rgb <= rgb_next;
  end

endmodule

// File: tb/tb_pong_anim_graph.sv
// tb/tb_pong_anim_graph.sv - directed self-checking bench for pong_anim_graph
module tb_pong_anim_graph;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_on = 1'b0;
  logic [9:0]  pixl_x = 10'd5;
  logic [9:0]  pixl_y = 10'd5;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic [11:0] rgb;
  logic        hit;
  logic        miss;

  int n_tests = 0;
  int n_fail  = 0;
  int hit_tot = 0;
  int miss_tot = 0;

  pong_anim_graph dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vid_on  (vid_on),
    .pixl_x  (pixl_x),
    .pixl_y  (pixl_y),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .rgb     (rgb),
    .hit     (hit),
    .miss    (miss)
  );

  always #5 clk = ~clk;

  // pulse counters: a 1-clk pulse is counted once, a stuck pulse many times
  always @(negedge clk) begin
    if (hit)  hit_tot  <= hit_tot + 1;
    if (miss) miss_tot <= miss_tot + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one frame: present (0,481) for one clk, then let tick and update settle
  task automatic frame();
    @(negedge clk);
    pixl_x = 10'd0;
    pixl_y = 10'd481;
    @(negedge clk);
    pixl_x = 10'd5;
    pixl_y = 10'd5;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pix(input int x, input int y, input logic von, input int exp, input string tag);
    @(negedge clk);
    pixl_x = 10'(x);
    pixl_y = 10'(y);
    vid_on = von;
    @(posedge clk);
    #1 check(tag, int'(rgb), exp);
  endtask

  int max_y;
  int h0, m0;
  logic found;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rgb",   int'(rgb), 0);
    check("rst_hit",   int'(hit), 0);
    check("rst_miss",  int'(miss), 0);
    check("rst_pad",   int'(dut.pad_top), 204);
    check("rst_bx",    int'(dut.ball_x), 320);
    check("rst_by",    int'(dut.ball_y), 236);
    check("rst_state", int'(dut.state), 0);
    check("rst_count", int'(dut.count), 0);

    // ---------------- render ----------------
    pix(322, 240, 1'b1, 'hF00, "rgb_ball");
    pix(327, 243, 1'b1, 'hF00, "rgb_ball_corner");
    pix(328, 240, 1'b1, 'h000, "rgb_ball_right_out");
    pix(33,  240, 1'b1, 'h00F, "rgb_wall");
    pix(35,  479, 1'b1, 'h00F, "rgb_wall_edge");
    pix(601, 210, 1'b1, 'h0F0, "rgb_pad");
    pix(601, 276, 1'b1, 'h000, "rgb_pad_below");
    pix(100, 100, 1'b1, 'h000, "rgb_bg");
    pix(322, 240, 1'b0, 'h000, "rgb_vid_off");
    @(negedge clk);
    vid_on = 1'b0;
    pixl_x = 10'd5;
    pixl_y = 10'd5;

    // ---------------- serve count ----------------
    repeat (59) frame();
    check("serve59_state", int'(dut.state), 0);
    check("serve59_count", int'(dut.count), 59);
    frame();
    check("serve60_state", int'(dut.state), 1);
    check("serve60_count", int'(dut.count), 0);
    check("serve60_bx",    int'(dut.ball_x), 320);

    // ---------------- paddle clamp ----------------
    btn_dn = 1'b1;
    repeat (70) frame();
    check("pad_clamp_lo", int'(dut.pad_top), 408);
    btn_dn = 1'b0;
    btn_up = 1'b1;
    repeat (110) frame();
    check("pad_clamp_hi", int'(dut.pad_top), 0);
    btn_up = 1'b0;
    btn_dn = 1'b1;
    repeat (10) frame();
    check("pad_step", int'(dut.pad_top), 40);
    btn_up = 1'b1;
    repeat (5) frame();
    check("pad_both", int'(dut.pad_top), 40);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (3) frame();
    check("pad_none", int'(dut.pad_top), 40);

    // ---------------- asynchronous reset mid-frame ----------------
    @(negedge clk);
    pixl_x = 10'd33;
    pixl_y = 10'd240;
    vid_on = 1'b1;
    @(negedge clk);
    check("pre_rst_rgb", int'(rgb), 'h00F);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rgb",   int'(rgb), 0);
    check("arst_pad",   int'(dut.pad_top), 204);
    check("arst_bx",    int'(dut.ball_x), 320);
    check("arst_by",    int'(dut.ball_y), 236);
    check("arst_state", int'(dut.state), 0);
    check("arst_count", int'(dut.count), 0);
    vid_on = 1'b0;
    pixl_x = 10'd5;
    pixl_y = 10'd5;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ---------------- bottom bounce and paddle hit ----------------
    btn_dn = 1'b1;
    max_y = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      frame();
      if (dut.state == 1'b1 && int'(dut.ball_y) > max_y) max_y = int'(dut.ball_y);
      found = (dut.state == 1'b1) && (dut.ball_x == 10'd592);
    end
    check("hit_reach_592", int'(found), 1);
    check("bounce_max_y",  max_y, 472);
    check("hit_pre_pad",   int'(dut.pad_top), 408);
    check("hit_pre_y",     int'(dut.ball_y), 436);
    check("hit_none_yet",  hit_tot, 0);
    h0 = hit_tot;
    m0 = miss_tot;
    frame();
    check("hit_pulse",   hit_tot - h0, 1);
    check("hit_next_x",  int'(dut.ball_x), 590);
    check("hit_next_y",  int'(dut.ball_y), 434);
    frame();
    check("hit_single",  hit_tot - h0, 1);
    check("hit_x_left",  int'(dut.ball_x), 588);
    check("hit_no_miss", miss_tot - m0, 0);
    btn_dn = 1'b0;

    // ---------------- miss ----------------
    do_reset();
    h0 = hit_tot;
    m0 = miss_tot;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      frame();
      found = (dut.state == 1'b1) && (dut.ball_x == 10'd630);
    end
    check("miss_reach_630", int'(found), 1);
    check("miss_pre_y",     int'(dut.ball_y), 398);
    check("miss_no_hit",    hit_tot - h0, 0);
    check("miss_none_yet",  miss_tot - m0, 0);
    frame();
    check("miss_pulse", miss_tot - m0, 1);
    check("miss_bx",    int'(dut.ball_x), 320);
    check("miss_by",    int'(dut.ball_y), 236);
    check("miss_state", int'(dut.state), 0);
    check("miss_count", int'(dut.count), 0);
    frame();
    check("miss_single", miss_tot - m0, 1);
    check("miss_serve1", int'(dut.count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
